// File: rtl/mult_sequencer.sv
// Iterative shift-add multiplier controller for the MULT path: one partial
// product per cycle, sign fix-up, then a one-cycle done pulse with {hi,lo}.
module mult_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             abort,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_FIX,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_next_state;

  logic [2*WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_mplier;
  logic [CNT_W-1:0]     r_count;
  logic                 r_neg;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;

  logic                 w_can_start;
  logic                 w_accept;
  logic                 w_last_iter;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic [2*WIDTH-1:0]   w_product;

  // A request is taken only between operations, and a concurrent flush drops it.
  assign w_can_start = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_accept    = w_can_start && start && !abort;
  assign w_last_iter = (r_count == CNT_W'(WIDTH - 1));

  // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude.
  assign w_a_mag   = (is_signed && op_a[WIDTH-1]) ? -op_a : op_a;
  assign w_b_mag   = (is_signed && op_b[WIDTH-1]) ? -op_b : op_b;
  assign w_product = r_neg ? -r_acc : r_acc;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next_state = S_BUSY;
      end
      S_BUSY: begin
        if (abort)            w_next_state = S_IDLE;
        else if (w_last_iter) w_next_state = S_FIX;
      end
      S_FIX: begin
        w_next_state = abort ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        w_next_state = w_accept ? S_BUSY : S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_count  <= '0;
      r_neg    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      if (w_accept) begin
        r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
        r_mplier <= w_b_mag;
        r_acc    <= '0;
        r_count  <= '0;
        r_neg    <= is_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
      end else if (r_state == S_BUSY) begin
        if (r_mplier[0]) r_acc <= r_acc + r_mcand;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_count  <= r_count + CNT_W'(1);
      end

      // The result registers move only when a fix-up completes unflushed.
      if ((r_state == S_FIX) && !abort) begin
        r_hi <= w_product[2*WIDTH-1:WIDTH];
        r_lo <= w_product[WIDTH-1:0];
      end
    end
  end

  assign busy  = (r_state == S_BUSY) || (r_state == S_FIX);
  assign done  = (r_state == S_DONE);
  assign stall = busy || w_accept;
  assign hi    = r_hi;
  assign lo    = r_lo;

endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer: directed corner cases plus random
// operands compared against a plain-arithmetic 64-bit product model.
module tb_mult_sequencer;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         is_signed;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         abort;
  logic         stall;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_checks = 0;
  int n_errors = 0;

  logic [2*W-1:0] exp_prod = '0;
  logic [2*W-1:0] pend     = '0;
  logic [W-1:0]   corner_vals [5] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF,
                                      32'h8000_0000, 32'h7FFF_FFFF};

  always #5 clk = ~clk;

  mult_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .op_a      (op_a),
    .op_b      (op_b),
    .abort     (abort),
    .stall     (stall),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_product(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic s);
    longint sa;
    longint sb;
    logic [63:0] ua;
    logic [63:0] ub;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'b0, a};
    ub = {32'b0, b};
    return ua * ub;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request in an IDLE/DONE cycle and clock it in.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    op_a      = a;
    op_b      = b;
    is_signed = s;
    start     = 1'b1;
    #1;
    check("stall_on_start", stall, 1);
    check("busy_before_accept", busy, 0);
    step();
    start = 1'b0;
    pend  = ref_product(a, b, s);
  endtask

  task automatic wait_done(output int n, output int busy_cycles);
    n           = 0;
    busy_cycles = 0;
    while (done !== 1'b1 && n < 200) begin
      if (busy === 1'b1) busy_cycles++;
      step();
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s);
    int n;
    int bc;
    launch(a, b, s);
    wait_done(n, bc);
    check({tag, "_latency"}, n, LAT);
    check({tag, "_busy_cycles"}, bc, LAT);
    exp_prod = pend;
    check({tag, "_result"}, {hi, lo}, exp_prod);
    step();
    check({tag, "_done_pulse"}, {done, busy}, 2'b00);
    check({tag, "_result_hold"}, {hi, lo}, exp_prod);
  endtask

  task automatic count_done(input int cycles, output int seen);
    seen = 0;
    repeat (cycles) begin
      step();
      if (done === 1'b1) seen++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int n2;
    int bc;
    int seen;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    int           k;

    rst = 1'b1; start = 1'b0; abort = 1'b0; is_signed = 1'b0; op_a = '0; op_b = '0;
    step();
    step();
    check("reset_hilo", {hi, lo}, 64'h0);
    check("reset_done_busy", {done, busy}, 2'b00);
    check("reset_stall_idle", stall, 0);
    start = 1'b1;
    #1;
    check("reset_stall_follows_start", stall, 1);
    start = 1'b0;
    step();
    rst = 1'b0;
    step();

    run_op("u3x5", 32'd3, 32'd5, 1'b0);
    check("u3x5_lo", lo, 32'h0000_000F);
    run_op("umax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("umax_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op("sm1x1", 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    check("sm1x1_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("sminsq", 32'h8000_0000, 32'h8000_0000, 1'b1);
    check("sminsq_hilo", {hi, lo}, 64'h4000_0000_0000_0000);
    run_op("sminx1", 32'h8000_0000, 32'h0000_0001, 1'b1);
    check("sminx1_hilo", {hi, lo}, 64'hFFFF_FFFF_8000_0000);
    run_op("u7x6", 32'd7, 32'd6, 1'b0);
    check("u7x6_lo", lo, 32'd42);

    // Flush on the 10th BUSY cycle.
    launch(32'd9, 32'd9, 1'b0);
    repeat (9) step();
    abort = 1'b1;
    #1;
    check("abort_stall_busy", stall, 1);
    step();
    abort = 1'b0;
    check("abort_to_idle", {done, busy}, 2'b00);
    count_done(40, seen);
    check("abort_no_done", seen, 0);
    check("abort_lo_kept", lo, 32'd42);

    // start while busy must be ignored.
    launch(32'd123, 32'd456, 1'b0);
    repeat (5) step();
    op_a = 32'd7; op_b = 32'd7; start = 1'b1;
    repeat (3) step();
    start = 1'b0;
    wait_done(n, bc);
    check("midstart_latency", n + 8, LAT);
    exp_prod = pend;
    check("midstart_result", {hi, lo}, exp_prod);
    step();

    // abort beats start in IDLE.
    op_a = 32'd5; op_b = 32'd5; start = 1'b1; abort = 1'b1;
    #1;
    check("idle_abort_stall", stall, 0);
    step();
    start = 1'b0; abort = 1'b0;
    check("idle_abort_dropped", busy, 0);

    // Reset on the 5th BUSY cycle.
    launch(32'hDEAD, 32'hBEEF, 1'b0);
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_prod = '0;
    check("rst_mid_state", {done, busy, stall}, 3'b000);
    check("rst_mid_hilo", {hi, lo}, exp_prod);
    count_done(40, seen);
    check("rst_mid_no_done", seen, 0);
    run_op("u2x2", 32'd2, 32'd2, 1'b0);
    check("u2x2_lo", lo, 32'd4);

    // Back-to-back issue from the DONE cycle.
    launch(32'd4, 32'd4, 1'b0);
    wait_done(n, bc);
    check("b2b_first_latency", n, LAT);
    exp_prod = pend;
    check("b2b_first_lo", lo, 32'd16);
    launch(32'd10, 32'd10, 1'b0);
    check("b2b_busy_after_done", busy, 1);
    wait_done(n2, bc);
    check("b2b_interval", n2 + 1, LAT + 1);
    exp_prod = pend;
    check("b2b_second_lo", lo, 32'd100);

    // abort beats start in DONE.
    start = 1'b1; abort = 1'b1; op_a = 32'd3; op_b = 32'd3;
    #1;
    check("done_abort_stall", stall, 0);
    step();
    start = 1'b0; abort = 1'b0;
    check("done_abort_dropped", {done, busy}, 2'b00);
    check("done_abort_hilo", {hi, lo}, exp_prod);

    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 2) == 0) ? corner_vals[$urandom_range(0, 4)] : W'($urandom);
      b = ($urandom_range(0, 2) == 0) ? corner_vals[$urandom_range(0, 4)] : W'($urandom);
      s = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) begin
        k = $urandom_range(1, LAT);
        launch(a, b, s);
        repeat (k - 1) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("rand_abort_idle", {done, busy}, 2'b00);
        check("rand_abort_hilo", {hi, lo}, exp_prod);
      end else begin
        run_op("rand", a, b, s);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mult_sequencer.md
# mult_sequencer

Multi-cycle controller for the MULT path: accepts a multiply request from the decode/execute stage, runs an iterative shift-add multiplication over WIDTH cycles, and writes the 2·WIDTH-bit product into the HI/LO result registers. It holds the pipeline via `stall` while busy, supports signed and unsigned operands, and can be aborted on a pipeline flush. It sits beside the single-cycle ALU, which keeps handling all other operations.

## Interface
- `WIDTH`, default 32: operand width. HI and LO are each WIDTH bits.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  request a multiply. Sampled only in IDLE or DONE.
- `is_signed`  in  1  1 means two's-complement operands; 0 means unsigned. Sampled with `start`.
- `op_a`  in  WIDTH  multiplicand. Sampled with `start`.
- `op_b`  in  WIDTH  multiplier. Sampled with `start`.
- `abort`  in  1  flush; cancels an in-flight operation.
- `stall`  out  1  pipeline hold request (combinational).
- `busy`  out  1  high in BUSY and FIX.
- `done`  out  1  one-cycle pulse while in DONE.
- `hi`  out  WIDTH  upper half of the last completed product.
- `lo`  out  WIDTH  lower half of the last completed product.

## Operation
- States: IDLE, BUSY, FIX, DONE. Internal registers: `mcand` (2·WIDTH bits), `mplier` (WIDTH bits), `acc` (2·WIDTH bits), `count` (log2(WIDTH)+1 bits), `neg` (1 bit).
- IDLE or DONE with `start`=1 and `abort`=0: load operands and go to BUSY.
  - If `is_signed`=1, load the magnitudes of the operands and set `neg` = `op_a`[MSB] ^ `op_b`[MSB].
  - If `is_signed`=0, load the raw operands and set `neg`=0.
  - Clear `acc` and `count`.
  - A magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which fits in an unsigned WIDTH-bit value.
- BUSY, one iteration per cycle:
  - If `mplier`[0]=1, then `acc` += `mcand`.
  - Shift `mcand` left by 1 and `mplier` right by 1; increment `count`.
  - After WIDTH iterations (`count`=WIDTH-1 on that edge), go to FIX.
- FIX: `{hi,lo}` = `neg` ? -`acc` : `acc`, computed modulo 2^(2·WIDTH). Then go to DONE.
- DONE: `done`=1 for exactly one cycle. Next state is BUSY if a new `start` is accepted, otherwise IDLE.
- IDLE with no `start`, or with `abort`=1: stay in IDLE.
- `start` in BUSY or FIX: ignored. The operation in flight is unaffected and there is no queueing.
- `abort`=1 in BUSY or FIX: go to IDLE on the next edge. `hi`/`lo` keep their previous values and no `done` pulse is produced.
- `abort` and `start` both high in IDLE or DONE: `abort` wins and the request is dropped.
- `hi`/`lo` change only on the FIX→DONE edge and under `rst`.
- `stall` = `busy` | (`start` & (state==IDLE | state==DONE) & ~`abort`).

## Timing
- Reset values: state IDLE, `hi`=0, `lo`=0, `done`=0, `busy`=0, `count`=0, `neg`=0. `stall` then follows `start` combinationally.
- `rst` dominates everything, including mid-operation: IDLE next cycle, `hi`/`lo` cleared, no `done`.
- Latency: with `start` accepted at edge T:
  - BUSY on edges T+1 … T+WIDTH.
  - FIX at edge T+WIDTH+1, when `hi`/`lo` are written.
  - `done` high during cycle T+WIDTH+1 → T+WIDTH+2.
  - With WIDTH=32, `done` goes high 33 edges after acceptance.
- Back-to-back: a `start` in the DONE cycle is accepted at that edge. Issue interval is WIDTH+2 cycles.
- `busy` is registered: high from T+1 through the FIX cycle, low in DONE.
- `stall` is combinational and rises in the same cycle as an accepted `start`, so the requesting instruction is held.

## Test plan
- Unsigned 3×5, `is_signed`=0 → `hi`=0x00000000, `lo`=0x0000000F. `done` is high exactly 33 edges after acceptance; `busy` is high for 33 cycles.
- Unsigned 0xFFFFFFFF×0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001. Signed 0xFFFFFFFF×0x00000001 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFF.
- Signed 0x80000000×0x80000000 → `hi`=0x40000000, `lo`=0x00000000. Signed 0x80000000×0x00000001 → `hi`=0xFFFFFFFF, `lo`=0x80000000.
- Complete 7×6 (`lo`=42). Then start 9×9 and assert `abort` on the 10th BUSY cycle → IDLE next edge, no `done`, `lo` stays 42. Also assert `start` mid-BUSY → ignored, and the result equals the original operands' product.
- Assert `rst` on the 5th BUSY cycle → next cycle is IDLE with `hi`=`lo`=0 and `done`=`busy`=0. A subsequent 2×2 yields `lo`=4.
- Back-to-back: assert `start` (10×10) during the `done` cycle of 4×4 → `lo`=16 is visible in that cycle, the next `done` arrives exactly 34 cycles after the first, and then `lo`=100.
